// File: rtl/nor_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nor_chk_pkg
// Description : Shared types, constants and the golden 4-input NOR model.
// Revision    : 1.0 - initial release
// ============================================================================
package nor_chk_pkg;

    localparam int          VEC_W       = 4;
    localparam logic [15:0] ALL_COVERED = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic nor4(input logic [VEC_W-1:0] vec);
        return ~(vec[3] | vec[2] | vec[1] | vec[0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vec_delay_line
// Description : DEPTH-stage shift register with synchronous clear; DEPTH=0
//               is a combinational bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, clr};
            assign dout        = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
                if (clr) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_d[i] = '0;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/nor_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : nor_response_checker
// Description : Checks NUM_OUT NOR-gate outputs against the golden model,
//               counts mismatches, captures the first failure and tracks
//               coverage of all 16 input vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module nor_response_checker
    import nor_chk_pkg::*;
#(
    parameter int NUM_OUT = 3,
    parameter int LAT     = 1,
    parameter int ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [VEC_W-1:0]   in_vec,
    input  logic [NUM_OUT-1:0] dut_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [15:0]        cover_map,
    output logic               first_fail_valid,
    output logic [VEC_W-1:0]   first_fail_vec,
    output logic [NUM_OUT-1:0] first_fail_out
);

    localparam int         DL_W    = VEC_W + 1;
    localparam [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t               state_q, state_d;
    logic [ERR_W-1:0]     err_count_q, err_count_d;
    logic [15:0]          cover_map_q, cover_map_d;
    logic                 ff_valid_q, ff_valid_d;
    logic [VEC_W-1:0]     ff_vec_q, ff_vec_d;
    logic [NUM_OUT-1:0]   ff_out_q, ff_out_d;

    logic [DL_W-1:0]      dl_in, dl_out;
    logic                 dl_clr;
    logic                 d_valid;
    logic [VEC_W-1:0]     d_vec;
    logic                 exp_bit;
    logic [NUM_OUT-1:0]   mis;

    assign dl_in            = {in_valid, in_vec};
    assign {d_valid, d_vec} = dl_out;

    vec_delay_line #(
        .DEPTH (LAT),
        .WIDTH (DL_W)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .clr  (dl_clr),
        .din  (dl_in),
        .dout (dl_out)
    );

    always_comb begin
        state_d     = state_q;
        err_count_d = err_count_q;
        cover_map_d = cover_map_q;
        ff_valid_d  = ff_valid_q;
        ff_vec_d    = ff_vec_q;
        ff_out_d    = ff_out_q;
        dl_clr      = 1'b0;
        exp_bit     = nor4(d_vec);
        mis         = dut_out ^ {NUM_OUT{exp_bit}};

        case (state_q)
            IDLE, DONE: begin
                // A new run wipes all statistics and any in-flight samples.
                if (start) begin
                    state_d     = RUN;
                    err_count_d = '0;
                    cover_map_d = '0;
                    ff_valid_d  = 1'b0;
                    ff_vec_d    = '0;
                    ff_out_d    = '0;
                    dl_clr      = 1'b1;
                end
            end
            RUN: begin
                if (d_valid) begin
                    cover_map_d[d_vec] = 1'b1;
                    if (|mis) begin
                        if (err_count_q != ERR_MAX) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                        if (!ff_valid_q) begin
                            ff_valid_d = 1'b1;
                            ff_vec_d   = d_vec;
                            ff_out_d   = dut_out;
                        end
                    end
                    if (cover_map_d == ALL_COVERED) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            err_count_q <= '0;
            cover_map_q <= '0;
            ff_valid_q  <= 1'b0;
            ff_vec_q    <= '0;
            ff_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            err_count_q <= err_count_d;
            cover_map_q <= cover_map_d;
            ff_valid_q  <= ff_valid_d;
            ff_vec_q    <= ff_vec_d;
            ff_out_q    <= ff_out_d;
        end
    end

    assign busy             = (state_q == RUN);
    assign done             = (state_q == DONE);
    assign pass             = (state_q == DONE) && (err_count_q == '0);
    assign err_count        = err_count_q;
    assign cover_map        = cover_map_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_out   = ff_out_q;

endmodule
`default_nettype wire

// File: tb/tb_nor_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_nor_response_checker
// Description : Directed self-checking bench; unit A uses LAT=1/ERR_W=8,
//               unit B uses LAT=0/ERR_W=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nor_response_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_start = 1'b0, a_valid = 1'b0;
    logic [3:0] a_vec = '0;
    logic [2:0] a_out = '0;
    logic       a_busy, a_done, a_pass, a_ffv;
    logic [7:0] a_err;
    logic [15:0] a_cov;
    logic [3:0] a_ffvec;
    logic [2:0] a_ffout;

    logic       b_start = 1'b0, b_valid = 1'b0;
    logic [3:0] b_vec = '0;
    logic [2:0] b_out = '0;
    logic       b_busy, b_done, b_pass, b_ffv;
    logic [1:0] b_err;
    logic [15:0] b_cov;
    logic [3:0] b_ffvec;
    logic [2:0] b_ffout;

    nor_response_checker #(.NUM_OUT(3), .LAT(1), .ERR_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .in_valid(a_valid), .in_vec(a_vec),
        .dut_out(a_out), .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_count(a_err), .cover_map(a_cov), .first_fail_valid(a_ffv),
        .first_fail_vec(a_ffvec), .first_fail_out(a_ffout)
    );

    nor_response_checker #(.NUM_OUT(3), .LAT(0), .ERR_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_valid), .in_vec(b_vec),
        .dut_out(b_out), .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_count(b_err), .cover_map(b_cov), .first_fail_valid(b_ffv),
        .first_fail_vec(b_ffvec), .first_fail_out(b_ffout)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Bench-side state modelling the one-cycle gate latency seen by unit A.
    logic       a_prev_v    = 1'b0;
    logic [3:0] a_prev_vec  = '0;
    logic [2:0] a_prev_mask = '0;

    // A NOR output is 1 only when every input is 0.
    function automatic logic [2:0] good(input logic [3:0] v);
        return (v == 4'd0) ? 3'b111 : 3'b000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step_a(input logic v, input logic [3:0] vec, input logic [2:0] mask);
        a_valid     = v;
        a_vec       = vec;
        a_out       = a_prev_v ? (good(a_prev_vec) ^ a_prev_mask) : 3'b000;
        a_prev_v    = v;
        a_prev_vec  = vec;
        a_prev_mask = mask;
        tick();
    endtask

    task automatic start_a;
        a_start  = 1'b1;
        a_valid  = 1'b0;
        a_out    = '0;
        a_prev_v = 1'b0;
        tick();
        a_start  = 1'b0;
    endtask

    // Vectors 0..15 then one flush cycle; mask flips outputs for vector 0 only.
    task automatic sweep_a(input logic [2:0] mask0);
        for (int i = 0; i < 16; i++) begin
            step_a(1'b1, 4'(i), (i == 0) ? mask0 : 3'b000);
        end
        check("a_sweep_not_done_early", {31'd0, a_done}, 32'd0);
        check("a_sweep_cov_15", {16'd0, a_cov}, 32'h7FFF);
        step_a(1'b0, 4'd0, 3'b000);
    endtask

    task automatic step_b(input logic v, input logic [3:0] vec, input logic [2:0] out);
        b_valid = v;
        b_vec   = vec;
        b_out   = out;
        tick();
    endtask

    initial begin
        // Reset
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_done", {31'd0, a_done}, 32'd0);
        check("rst_pass", {31'd0, a_pass}, 32'd0);
        check("rst_err",  {24'd0, a_err}, 32'd0);
        check("rst_cov",  {16'd0, a_cov}, 32'd0);
        check("rst_ffv",  {31'd0, a_ffv}, 32'd0);
        check("rst_b_busy", {31'd0, b_busy}, 32'd0);

        // Exhaustive pass, LAT=1
        start_a();
        check("a1_busy", {31'd0, a_busy}, 32'd1);
        sweep_a(3'b000);
        check("a1_done", {31'd0, a_done}, 32'd1);
        check("a1_busy_low", {31'd0, a_busy}, 32'd0);
        check("a1_pass", {31'd0, a_pass}, 32'd1);
        check("a1_err",  {24'd0, a_err}, 32'd0);
        check("a1_cov",  {16'd0, a_cov}, 32'hFFFF);
        check("a1_ffv",  {31'd0, a_ffv}, 32'd0);
        // Samples in DONE are not checked
        step_a(1'b1, 4'd0, 3'b111);
        step_a(1'b1, 4'd1, 3'b111);
        step_a(1'b0, 4'd0, 3'b000);
        check("a1_hold_err", {24'd0, a_err}, 32'd0);
        check("a1_hold_pass", {31'd0, a_pass}, 32'd1);

        // Single fault, restarted from DONE
        start_a();
        check("a2_clr_busy", {31'd0, a_busy}, 32'd1);
        check("a2_clr_cov", {16'd0, a_cov}, 32'd0);
        sweep_a(3'b010);
        check("a2_done", {31'd0, a_done}, 32'd1);
        check("a2_pass", {31'd0, a_pass}, 32'd0);
        check("a2_err",  {24'd0, a_err}, 32'd1);
        check("a2_ffv",  {31'd0, a_ffv}, 32'd1);
        check("a2_ffvec", {28'd0, a_ffvec}, 32'd0);
        check("a2_ffout", {29'd0, a_ffout}, 32'h5);

        // Gapped / duplicate stimulus with start ignored in RUN
        start_a();
        check("a3_cleared_err", {24'd0, a_err}, 32'd0);
        check("a3_cleared_ffv", {31'd0, a_ffv}, 32'd0);
        step_a(1'b1, 4'd5, 3'b000);
        a_start = 1'b1;
        step_a(1'b0, 4'd9, 3'b000);
        a_start = 1'b0;
        step_a(1'b1, 4'd5, 3'b000);
        step_a(1'b1, 4'd3, 3'b000);
        step_a(1'b0, 4'd0, 3'b000);
        check("a3_cov_35", {16'd0, a_cov}, 32'h0028);
        check("a3_busy", {31'd0, a_busy}, 32'd1);
        check("a3_not_done", {31'd0, a_done}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            if (i != 3 && i != 5) step_a(1'b1, 4'(i), 3'b000);
        end
        step_a(1'b0, 4'd0, 3'b000);
        check("a3_cov_no15", {16'd0, a_cov}, 32'h7FFF);
        check("a3_still_run", {31'd0, a_done}, 32'd0);
        step_a(1'b1, 4'd15, 3'b000);
        step_a(1'b0, 4'd0, 3'b000);
        check("a3_done_on_16th", {31'd0, a_done}, 32'd1);
        check("a3_pass", {31'd0, a_pass}, 32'd1);

        // Reset mid-run
        start_a();
        for (int i = 0; i < 7; i++) step_a(1'b1, 4'(i), 3'b000);
        step_a(1'b0, 4'd0, 3'b000);
        check("a4_cov7", {16'd0, a_cov}, 32'h007F);
        rst = 1'b1;
        a_start = 1'b1;
        tick();
        rst = 1'b0;
        a_start = 1'b0;
        check("a4_rst_busy", {31'd0, a_busy}, 32'd0);
        check("a4_rst_cov", {16'd0, a_cov}, 32'd0);
        check("a4_rst_done", {31'd0, a_done}, 32'd0);
        start_a();
        sweep_a(3'b000);
        check("a4_rerun_pass", {31'd0, a_pass}, 32'd1);

        // Saturation on unit B (LAT=0, ERR_W=2), dut_out stuck high
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("b1_busy", {31'd0, b_busy}, 32'd1);
        for (int i = 0; i < 3; i++) step_b(1'b1, 4'(i), 3'b111);
        check("b1_err2", {30'd0, b_err}, 32'd2);
        for (int i = 3; i < 10; i++) step_b(1'b1, 4'(i), 3'b111);
        check("b1_err_sat", {30'd0, b_err}, 32'd3);
        check("b1_ffv", {31'd0, b_ffv}, 32'd1);
        check("b1_ffvec", {28'd0, b_ffvec}, 32'd1);
        check("b1_ffout", {29'd0, b_ffout}, 32'h7);
        for (int i = 10; i < 16; i++) step_b(1'b1, 4'(i), 3'b111);
        check("b1_done", {31'd0, b_done}, 32'd1);
        check("b1_pass", {31'd0, b_pass}, 32'd0);

        // LAT=0 exhaustive sweep
        b_start = 1'b1;
        step_b(1'b0, 4'd0, 3'b000);
        b_start = 1'b0;
        for (int i = 0; i < 15; i++) step_b(1'b1, 4'(i), good(4'(i)));
        check("b2_not_done", {31'd0, b_done}, 32'd0);
        step_b(1'b1, 4'd15, good(4'd15));
        check("b2_done", {31'd0, b_done}, 32'd1);
        check("b2_pass", {31'd0, b_pass}, 32'd1);
        check("b2_err", {30'd0, b_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nor_response_checker.md
Name: nor_response_checker

Overview:
- Receiving end of the 4-input NOR gate stimulus/response path. Consumes the applied 4-bit input vector and the N observed gate outputs (e.g. three structurally different NOR implementations).
- Compares each output against the golden NOR, counts mismatches and captures the first failure.
- Tracks coverage of all 16 input combinations and flags done/pass once the truth table is exhausted.
- Sits beside the gate in the lab top level or bench and replaces eyeball waveform checking.

Parameters:
- NUM_OUT, 3, number of gate outputs checked in parallel (1..8)
- LAT, 1, cycles between an input vector being presented and its outputs being valid on dut_out (0..4)
- ERR_W, 8, width of the saturating mismatch counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a check run
- in_valid  in  1  in_vec is a real stimulus this cycle
- in_vec  in  4  applied gate inputs {a,b,c,d}
- dut_out  in  NUM_OUT  observed gate outputs, LAT cycles after in_vec
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  valid when done; 1 = zero mismatches
- err_count  out  ERR_W  mismatching samples, saturating
- cover_map  out  16  bit k set once vector k has been checked
- first_fail_valid  out  1  a failure has been captured this run
- first_fail_vec  out  4  input vector of the first failing sample
- first_fail_out  out  NUM_OUT  dut_out of the first failing sample

Behaviour:
- Reset: state=IDLE; busy, done, pass, first_fail_valid = 0; err_count, cover_map, first_fail_vec and first_fail_out = 0; delay line cleared. Reset wins over every other input, including mid-run.
- FSM IDLE -> RUN on start. RUN -> DONE when cover_map, including this cycle's update, is all ones. DONE -> RUN on start. start is ignored in RUN.
- Entering RUN clears err_count, cover_map, first_fail_* and the delay line in the same edge. Samples are not checked during that start cycle.
- Delay line: LAT-deep shift register of {in_valid, in_vec}, shifting every cycle.
  - d_valid/d_vec = stage LAT output.
  - When LAT=0, d_valid/d_vec are in_valid/in_vec directly.
- Check applies only in RUN when d_valid=1:
  - exp = ~(d_vec[3]|d_vec[2]|d_vec[1]|d_vec[0])
  - mis = dut_out ^ {NUM_OUT{exp}}
  - Result is registered at the next edge.
- If mis != 0:
  - err_count increments, holding at 2^ERR_W-1.
  - If first_fail_valid=0, capture d_vec and dut_out and set first_fail_valid.
- cover_map[d_vec] is set on every checked sample, pass or fail.
- Transition to DONE happens on the same edge as the 16th distinct coverage bit. done=1 from the next cycle.
- pass = (err_count==0) while done=1, and 0 otherwise. It includes a mismatch on the final covering sample.
- Samples with d_valid=0 are ignored. Duplicate vectors recheck and count errors, but do not change coverage.
- In DONE, outputs hold and further samples are not checked.
- Simultaneous rst and start: reset wins.

Decomposition:
- Shared package nor_chk_pkg:
  - state enum {IDLE, RUN, DONE}
  - VEC_W=4
  - ALL_COVERED=16'hFFFF
  - golden function nor4(vec)
- One natural sub-module: vec_delay_line (parameterised depth LAT, width 5, synchronous clear), instanced once.

Test Plan:
- Exhaustive pass, LAT=1: start, then 16 consecutive vectors 0..15, dut_out driven as correct NOR delayed 1 cycle -> done=1 one cycle after the last check, pass=1, err_count=0, cover_map=FFFF, first_fail_valid=0.
- Single fault: same as above but output bit 1 is forced to 0 for vector 0 -> err_count=1, first_fail_vec=0, first_fail_out=3'b101, pass=0 at done.
- Gapped/duplicate stimulus: in_valid toggled 1,0,1; vectors 5,5,3 repeated -> no done. cover_map has only bits 3 and 5 set until all 16 are seen, with done exactly on the 16th distinct vector.
- Saturation, ERR_W=2: dut_out stuck at all-ones for 10 vectors -> err_count holds at 3. first_fail_vec is the first vector with nonzero value.
- Reset mid-run: after 7 checked vectors, pulse rst -> all outputs 0 and IDLE next cycle. A new start re-runs cleanly to pass=1.
- Restart from DONE and start-in-RUN: start while busy has no effect. start in DONE clears all stats and re-enters RUN. LAT=0 variant passes the exhaustive sweep.
